mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the CPU instruction-fetch port and its data port.
//  Each request is a sticky req/valid handshake; grants alternate round-robin; the access is sequenced
//  through issue, wait and response states. Sits between the CPU core and the unified instr/data SRAM.
// PARAMETERS
//  ADDR_W   32  byte-address width, passed to memory unchanged
//  DATA_W   32  data word width
//  MEM_LAT  1   memory read latency in cycles (>=1); rdata valid MEM_LAT edges after the sampling edge
// PORTS
//  clk      in   1       system clock, rising edge
//  rst      in   1       asynchronous, active-low reset
//  i_req    in   1       instruction fetch request, held until i_valid
//  i_addr   in   ADDR_W  fetch byte address
//  i_rdata  out  DATA_W  fetched word, meaningful while i_valid
//  i_valid  out  1       one-cycle fetch completion pulse
//  d_req    in   1       data request, held until d_valid
//  d_we     in   1       1=write, 0=read
//  d_addr   in   ADDR_W  data byte address
//  d_wdata  in   DATA_W  store data
//  d_rdata  out  DATA_W  load data, meaningful while d_valid on a read
//  d_valid  out  1       one-cycle completion pulse (reads and writes)
//  m_en     out  1       memory access strobe, exactly one cycle per access
//  m_we     out  1       memory write enable, only while m_en
//  m_addr   out  ADDR_W  memory byte address
//  m_wdata  out  DATA_W  memory write data
//  m_rdata  in   DATA_W  memory read data
//  busy     out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all outputs 0, last_grant=DATA (instruction wins first tie).
//  - All outputs are registered. Address, data and we are latched at grant; requesters need not hold them after grant.
//  - FSM: IDLE -> ISSUE on any req; ISSUE (m_en=1, m_we=latched we) -> WAIT with cnt=MEM_LAT-1;
//    WAIT decrements cnt; at cnt==0 latch m_rdata -> RESP; RESP pulses valid to the owner for 1 cycle;
//    RESP -> ISSUE if the OTHER requester has req=1, else -> IDLE.
//  - In RESP the owner is excluded from arbitration, even if its req is still high.
//  - Arbitration (IDLE): only one req -> grant it; both -> grant != last_grant; last_grant updated on grant.
//  - Latency, idle port, MEM_LAT=1: req seen cycle0 -> m_en cycle1 -> valid cycle3. Generally valid at cycle 2+MEM_LAT.
//  - Write: data written on the m_en edge; d_valid still pulses in RESP; d_rdata unchanged.
//  - rdata registers hold their value until the next read for the same port.
//  - req dropped before valid: the access still completes and valid still pulses; no abort.
//  - Misaligned addresses are passed through unchecked; sub-word access is unsupported.
//  - Reset mid-access: returns to IDLE immediately; in-flight access lost; no valid issued.
//  - Throughput: one access per 2+MEM_LAT cycles while both ports are saturated.
// STRUCTURE
//  - mem_arb_pkg: state localparams (IDLE, ISSUE, WAIT, RESP), grant ids (GNT_I=0, GNT_D=1).
//  - Sub-module rr_arb2: 2-way round-robin picker (req[1:0], last, exclude[1:0] -> gnt, gnt_id).
//  - Top: FSM, MEM_LAT down-counter ($clog2(MEM_LAT)+1 bits), latch registers.
// TESTING
//  - Lone fetch, i_addr=0x40, mem[0x40]=0x00A00093, MEM_LAT=1 -> m_en cycle1, i_valid=1 cycle3 with i_rdata=0x00A00093.
//  - Both req in cycle0 after reset -> fetch granted first; d granted from RESP with no IDLE gap; d_valid 3 cycles after i_valid.
//  - Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, then load 0x100 -> m_we only in its ISSUE cycle; load returns 0xDEADBEEF.
//  - Both req held high for 8 accesses -> strict alternation I,D,I,D...; no port served twice in a row.
//  - MEM_LAT=3, lone load -> valid at cycle 5; m_en high exactly 1 cycle; busy high cycles 1-5.
//  - rst pulled low during WAIT -> all outputs 0 asynchronously; no valid after release; next req is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and grant ids for the instr/data memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // One-hot request mask for a grant id: bit 0 is the fetch port, bit 1 the data port.
  function automatic logic [1:0] id_mask(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker with per-requester exclusion
import mem_arb_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] exclude,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic [1:0] eligible;

  assign eligible = req & ~exclude;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    gnt_id = GNT_I;
    if (eligible == 2'b11) begin
      gnt_id = ~last;
    end else if (eligible[1]) begin
      gnt_id = GNT_D;
    end
    gnt = (eligible == 2'b00) ? 2'b00 : id_mask(gnt_id);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous SRAM port between CPU fetch and data requests
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int            CW       = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          take;
  logic          owner;
  logic          last;
  logic          we_lat;
  logic [1:0]    gnt;
  logic [1:0]    exclude;
  logic          gnt_id;

  // The port just being answered may not win again straight out of RESP.
  assign exclude = (state == ST_RESP) ? id_mask(owner) : 2'b00;

  rr_arb2 u_arb (
    .req     ({d_req, i_req}),
    .last    (last),
    .exclude (exclude),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Next-state logic; a grant can be taken from IDLE or straight out of RESP.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|gnt) begin
          take     = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nx = ST_WAIT;
        cnt_nx   = CNT_INIT;
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nx = ST_RESP;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_RESP: begin
        if (|gnt) begin
          take     = 1'b1;
          state_nx = ST_ISSUE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the winning request so the requester may change its inputs after grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner   <= GNT_I;
      last    <= GNT_D;
      we_lat  <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (take) begin
      owner  <= gnt_id;
      last   <= gnt_id;
      we_lat <= (gnt_id == GNT_D) && d_we;
      m_addr <= (gnt_id == GNT_D) ? d_addr : i_addr;
      if (gnt_id == GNT_D) begin
        m_wdata <= d_wdata;
      end
    end
  end

  // Registered strobes derived from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      busy    <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      m_en    <= (state_nx == ST_ISSUE);
      m_we    <= take && (gnt_id == GNT_D) && d_we;
      busy    <= (state_nx != ST_IDLE);
      i_valid <= (state_nx == ST_RESP) && (owner == GNT_I);
      d_valid <= (state_nx == ST_RESP) && (owner == GNT_D);
    end
  end

  // Read data is taken on the last WAIT edge and held until that port's next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if ((state == ST_WAIT) && (cnt == '0)) begin
      if (owner == GNT_I) begin
        i_rdata <= m_rdata;
      end else if (!we_lat) begin
        d_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with MEM_LAT=1 and MEM_LAT=3
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic        i_req   [2];
  logic [31:0] i_addr  [2];
  logic [31:0] i_rdata [2];
  logic        i_valid [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata [2];
  logic        d_valid [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        busy    [2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_valid(i_valid[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_valid(d_valid[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_valid(i_valid[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_valid(d_valid[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1]), .busy(busy[1])
  );

  // Physical SRAMs: dut0 returns data one edge after sampling, dut1 three edges.
  logic [31:0] phys [2][256];
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    if (m_en[0]) begin
      if (m_we[0]) phys[0][m_addr[0][9:2]] <= m_wdata[0];
      else         m_rdata[0] <= phys[0][m_addr[0][9:2]];
    end
    if (m_en[1] && m_we[1]) phys[1][m_addr[1][9:2]] <= m_wdata[1];
    if (m_en[1] && !m_we[1]) p1 <= phys[1][m_addr[1][9:2]];
    p2         <= p1;
    m_rdata[1] <= p2;
  end

  // Reference model: an access granted at edge g occupies cycles g..g+lat+1,
  // strobing the memory in its first cycle and answering in its last.
  logic [31:0] refm [2][256];
  int          ph    [2] = '{-1, -1};
  logic        mown  [2] = '{1'b0, 1'b0};
  logic        mlast [2] = '{1'b1, 1'b1};
  logic        mwe   [2] = '{1'b0, 1'b0};
  logic [31:0] maddr [2] = '{32'h0, 32'h0};
  logic [31:0] mwd   [2] = '{32'h0, 32'h0};
  logic        e_men [2], e_mwe [2], e_ival [2], e_dval [2], e_busy [2];
  logic [31:0] e_ird [2], e_drd [2], e_maddr [2], e_mwd [2];

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      automatic int          lat;
      automatic int          np;
      automatic logic        ci, cd, own, we, g;
      automatic logic [31:0] a, wd;
      lat = (k == 0) ? 1 : 3;
      np  = ph[k];
      ci  = i_req[k];
      cd  = d_req[k];
      own = mown[k];
      we  = mwe[k];
      a   = maddr[k];
      wd  = mwd[k];
      if (!rst) begin
        ph[k] <= -1; mown[k] <= 1'b0; mlast[k] <= 1'b1; mwe[k] <= 1'b0;
        maddr[k] <= '0; mwd[k] <= '0;
        e_men[k] <= 1'b0; e_mwe[k] <= 1'b0; e_ival[k] <= 1'b0; e_dval[k] <= 1'b0;
        e_busy[k] <= 1'b0; e_ird[k] <= '0; e_drd[k] <= '0; e_maddr[k] <= '0; e_mwd[k] <= '0;
      end else begin
        if (np < 0 || np == lat + 1) begin
          if (np == lat + 1) begin
            if (own) cd = 1'b0;
            else     ci = 1'b0;
          end
          if (ci || cd) begin
            g   = (ci && cd) ? ~mlast[k] : cd;
            own = g;
            we  = g && d_we[k];
            a   = g ? d_addr[k] : i_addr[k];
            if (g) wd = d_wdata[k];
            mlast[k] <= g;
            np = 0;
          end else begin
            np = -1;
          end
        end else begin
          np = np + 1;
        end
        ph[k] <= np; mown[k] <= own; mwe[k] <= we; maddr[k] <= a; mwd[k] <= wd;
        e_busy[k]  <= (np >= 0);
        e_men[k]   <= (np == 0);
        e_mwe[k]   <= (np == 0) && we;
        e_maddr[k] <= a;
        e_mwd[k]   <= wd;
        e_ival[k]  <= (np == lat + 1) && !own;
        e_dval[k]  <= (np == lat + 1) && own;
        if (np == 0 && we) refm[k][a[9:2]] <= wd;
        if (np == lat + 1 && !own) e_ird[k] <= refm[k][a[9:2]];
        if (np == lat + 1 && own && !we) e_drd[k] <= refm[k][a[9:2]];
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h required=%h", nm, k, act, exp);
    end
  endtask

  // Every cycle, both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, busy[k], e_busy[k]);
        chk("m_en", k, m_en[k], e_men[k]);
        chk("m_we", k, m_we[k], e_mwe[k]);
        chk("i_valid", k, i_valid[k], e_ival[k]);
        chk("d_valid", k, d_valid[k], e_dval[k]);
        chk("i_rdata", k, i_rdata[k], e_ird[k]);
        chk("d_rdata", k, d_rdata[k], e_drd[k]);
        if (e_men[k]) chk("m_addr", k, m_addr[k], e_maddr[k]);
        if (e_mwe[k]) chk("m_wdata", k, m_wdata[k], e_mwd[k]);
      end
    end
  end

  task automatic access(input int k, input logic is_d, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output int men_n, output int we_n, output int busy_n);
    int c0;
    lat = -1; rd = '0; men_n = 0; we_n = 0; busy_n = 0;
    @(negedge clk);
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    c0 = cyc;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 0) begin
        i_addr[k] = 32'hFFFF_FFF0; d_addr[k] = 32'hFFFF_FFF0; d_wdata[k] = 32'h5555_AAAA;
      end
      if (m_en[k]) men_n++;
      if (m_we[k]) we_n++;
      if (busy[k]) busy_n++;
      if (is_d ? d_valid[k] : i_valid[k]) begin
        lat = cyc - c0;
        rd  = is_d ? d_rdata[k] : i_rdata[k];
        if (is_d) d_req[k] = 1'b0;
        else      i_req[k] = 1'b0;
      end
    end
    if (lat < 0) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0;
    end
  endtask

  int          lat, men_n, we_n, busy_n, c0, ti, td, nv, nval;
  logic [31:0] rd;
  logic        sq [8];
  int          tc [8];

  initial begin
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int a = 0; a < 256; a++) begin
        phys[k][a] = 32'h0;
        refm[k][a] = 32'h0;
      end
      phys[k][16] = 32'h00A0_0093; refm[k][16] = 32'h00A0_0093;
      phys[k][17] = 32'hCAFE_F00D; refm[k][17] = 32'hCAFE_F00D;
      phys[k][32] = 32'h1234_5678; refm[k][32] = 32'h1234_5678;
    end
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_m_en", 0, m_en[0], 1'b0);
    chk("rst_i_valid", 0, i_valid[0], 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Lone fetch, MEM_LAT=1.
    access(0, 1'b0, 1'b0, 32'h40, 32'h0, lat, rd, men_n, we_n, busy_n);
    chk("fetch_lat", 0, lat, 3);
    chk("fetch_data", 0, rd, 32'h00A0_0093);
    chk("fetch_men_cycles", 0, men_n, 1);

    // Both requests together right after reset.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    i_req[0] = 1'b1; i_addr[0] = 32'h40;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
    c0 = cyc; ti = -1; td = -1;
    for (int n = 0; n < 40 && (ti < 0 || td < 0); n++) begin
      @(negedge clk);
      if (i_valid[0] && ti < 0) begin ti = cyc - c0; i_req[0] = 1'b0; end
      if (d_valid[0] && td < 0) begin
        td = cyc - c0; d_req[0] = 1'b0;
        chk("both_d_data", 0, d_rdata[0], 32'h1234_5678);
      end
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("both_i_first", 0, ti, 3);
    chk("both_d_next", 0, td, 6);

    // Store then load back.
    access(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, lat, rd, men_n, we_n, busy_n);
    chk("store_lat", 0, lat, 3);
    chk("store_we_cycles", 0, we_n, 1);
    chk("store_men_cycles", 0, men_n, 1);
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, lat, rd, men_n, we_n, busy_n);
    chk("load_back", 0, rd, 32'hDEAD_BEEF);
    chk("load_we_cycles", 0, we_n, 0);

    // Saturated alternation; last winner was the data port.
    @(negedge clk);
    i_req[0] = 1'b1; i_addr[0] = 32'h44;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
    nv = 0;
    for (int n = 0; n < 100 && nv < 8; n++) begin
      @(negedge clk);
      if (i_valid[0] || d_valid[0]) begin
        sq[nv] = d_valid[0]; tc[nv] = cyc; nv++;
      end
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("alt_count", 0, nv, 8);
    if (nv > 0) chk("alt_first_is_fetch", 0, sq[0], 1'b0);
    for (int j = 1; j < nv; j++) begin
      chk("alt_order", 0, sq[j], !sq[j-1]);
      chk("alt_gap", 0, tc[j] - tc[j-1], 3);
    end
    for (int n = 0; n < 20 && busy[0]; n++) @(negedge clk);
    chk("alt_drain", 0, busy[0], 1'b0);

    // MEM_LAT=3 lone load.
    access(1, 1'b1, 1'b0, 32'h80, 32'h0, lat, rd, men_n, we_n, busy_n);
    chk("lat3_valid", 1, lat, 5);
    chk("lat3_data", 1, rd, 32'h1234_5678);
    chk("lat3_men_cycles", 1, men_n, 1);
    chk("lat3_busy_cycles", 1, busy_n, 5);
    @(negedge clk);
    chk("lat3_idle_after", 1, busy[1], 1'b0);

    // Reset while the fetch is waiting on memory.
    @(negedge clk);
    i_req[0] = 1'b1; i_addr[0] = 32'h44;
    @(negedge clk);
    @(negedge clk);
    i_req[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 0, busy[0], 1'b0);
    chk("arst_m_en", 0, m_en[0], 1'b0);
    chk("arst_i_valid", 0, i_valid[0], 1'b0);
    chk("arst_i_rdata", 0, i_rdata[0], 32'h0);
    chk("arst_m_addr", 0, m_addr[0], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    nval = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_valid[0]) nval++;
    end
    chk("arst_no_valid", 0, nval, 0);
    access(0, 1'b0, 1'b0, 32'h44, 32'h0, lat, rd, men_n, we_n, busy_n);
    chk("arst_next_lat", 0, lat, 3);
    chk("arst_next_data", 0, rd, 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
